regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port general-purpose register file with write-through bypass and a per-register pending scoreboard, for the pipelined MIPS core. It sits between decode (read ports, pending-operand check) and writeback. It has two write ports: port 0 for the ALU/load path and port 1 for long-latency units such as mult/div. Register 0 reads as zero, and the a0/v0/ra debug taps feed the syscall/display logic.

## Interface
Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth is 2**ADDR_W.
- NREAD, 2: number of read ports.
- BYPASS, 1: 1 forwards same-cycle write data to the read ports; 0 gives plain read-old-value.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low; clears all registers and pending bits.
- RA  in  NREAD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- RD  out  NREAD*DATA_W  read data, packed the same way.
- BUSY  out  NREAD  read port i targets a pending register.
- WE0  in  1  write enable, port 0.
- WA0  in  ADDR_W  write address, port 0.
- WD0  in  DATA_W  write data, port 0.
- WE1  in  1  write enable, port 1 (long-latency writeback).
- WA1  in  ADDR_W  write address, port 1.
- WD1  in  DATA_W  write data, port 1.
- SB_SET  in  1  mark register SB_SA pending (long-latency op issued).
- SB_SA  in  ADDR_W  scoreboard set address.
- A0, V0, RA_TAP  out  DATA_W each  contents of registers 4, 2, 31 (no bypass).

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus a pending bit per register.
- Register 0:
  - Writes to address 0 are ignored on both ports; SB_SET to 0 is ignored.
  - RD for address 0 is always 0 and BUSY for address 0 is always 0, including under bypass.
- Write: on the rising edge, each port with WEx=1 and WAx!=0 writes WDx. If both ports hit the same address, port 1 wins.
- Read: combinational.
  - BYPASS=0: RD returns the stored value.
  - BYPASS=1: if WE1 and WA1==RA[i]!=0, return WD1. Otherwise, if WE0 and WA0==RA[i]!=0, return WD0. Otherwise return the stored value.
- Scoreboard:
  - pending[a] is set on an edge with SB_SET=1 and SB_SA==a.
  - pending[a] is cleared on an edge with WE1=1 and WA1==a.
  - Port 0 writes never clear pending.
  - SB_SET and a port 1 clear on the same address in the same cycle: the set wins and the bit stays 1.
  - SB_SET on an already-pending register keeps it at 1.
- BUSY[i] = pending[RA[i]] & (RA[i]!=0).
  - With BYPASS=1, BUSY[i] is forced to 0 in the cycle WE1 writes RA[i], because the data is being forwarded.
  - Same-cycle SB_SET does not affect BUSY until the next cycle.
- Debug taps read stored values directly.

## Timing
- Reset asserted (RST=0) takes effect immediately, independent of CLK.
  - All registers go to 0, all pending bits go to 0.
  - RD, BUSY, A0, V0, RA_TAP read 0 unless bypass is active.
  - While RST=0, all writes and sets are blocked.
- Reset asserted mid-operation discards in-flight pending state. The first edge after RST rises performs normal updates.
- Write latency: 1 edge to stored state, 0 cycles to RD with BYPASS=1.
- Scoreboard latency: 1 edge from SB_SET to BUSY=1. A clear is visible combinationally when BYPASS=1, otherwise after 1 edge.
- There is no handshake. Stalling on BUSY is the decode unit's responsibility.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse RST low between edges -> RD for r5 is 0 immediately, A0/V0/RA_TAP are 0, BUSY is 0.
- Basic write/read: WE0, WA0=3, WD0=0x12345678 -> after the edge, both read ports with RA=3 return 0x12345678. With BYPASS=1, they also return it in the same cycle.
- Dual-write conflict: WE0 with WA0=7, WD0=0x1, and WE1 with WA1=7, WD1=0x2, in one cycle -> r7 holds 0x2, and the bypass value in that cycle is 0x2.
- Register 0: write 0xFFFFFFFF to address 0 via both ports, and SB_SET with SB_SA=0 -> RD for r0 is 0 and BUSY is 0.
- Scoreboard:
  - SB_SET with SB_SA=2 -> from the next cycle, BUSY=1 on a port reading r2.
  - A port 0 write to r2 -> BUSY stays 1.
  - WE1 with WA1=2, WD1=0xAA -> with BYPASS=1, BUSY=0 and RD=0xAA in the same cycle, and BUSY=0 after the edge. V0=0xAA.
- Set/clear collision: r9 pending, then SB_SET with SB_SA=9 and WE1 with WA1=9 in the same cycle -> r9 holds WD1 and BUSY for r9 stays 1.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bundle of read, write and scoreboard signals between decode/writeback and regfile_mp.
// The master side drives addresses, write data and SB_SET. The slave side returns read data, BUSY and the debug taps.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] RA;
    logic [NREAD*DATA_W-1:0] RD;
    logic [NREAD-1:0]        BUSY;
    logic                    WE0;
    logic [ADDR_W-1:0]       WA0;
    logic [DATA_W-1:0]       WD0;
    logic                    WE1;
    logic [ADDR_W-1:0]       WA1;
    logic [DATA_W-1:0]       WD1;
    logic                    SB_SET;
    logic [ADDR_W-1:0]       SB_SA;
    logic [DATA_W-1:0]       A0;
    logic [DATA_W-1:0]       V0;
    logic [DATA_W-1:0]       RA_TAP;

    modport master (
        output RA, WE0, WA0, WD0, WE1, WA1, WD1, SB_SET, SB_SA,
        input  RD, BUSY, A0, V0, RA_TAP
    );

    modport slave (
        input  RA, WE0, WA0, WD0, WE1, WA1, WD1, SB_SET, SB_SA,
        output RD, BUSY, A0, V0, RA_TAP
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port GPR file with two write ports and optional write-through bypass.
// A per-register pending scoreboard tracks results still owed by long-latency units.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic        CLK,
    input  logic        RST,
    regfile_mp_if.slave bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              we0_ok;
    logic              we1_ok;

    assign we0_ok = bus.WE0 && (bus.WA0 != '0);
    assign we1_ok = bus.WE1 && (bus.WA1 != '0);

    // The set is applied after the clear, so a same-cycle set on the same address wins.
    always_comb begin
        pend_d = pend_q;
        if (bus.WE1)    pend_d[bus.WA1]   = 1'b0;
        if (bus.SB_SET) pend_d[bus.SB_SA] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            pend_q <= '0;
        end else begin
            if (we0_ok) mem_q[bus.WA0] <= bus.WD0;
            // Port 1 is assigned last, so it overrides port 0 on an address clash.
            if (we1_ok) mem_q[bus.WA1] <= bus.WD1;
            pend_q <= pend_d;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;
        logic [DATA_W-1:0] rd;

        assign ra   = bus.RA[g*ADDR_W +: ADDR_W];
        assign hit1 = (BYPASS != 0) && we1_ok && (bus.WA1 == ra);
        assign hit0 = (BYPASS != 0) && we0_ok && (bus.WA0 == ra);

        always_comb begin
            rd = mem_q[ra];
            if (ra == '0)  rd = '0;
            else if (hit1) rd = bus.WD1;
            else if (hit0) rd = bus.WD0;
        end

        assign bus.RD[g*DATA_W +: DATA_W] = rd;
        // A register being written back by port 1 is forwarded, so it no longer stalls decode.
        assign bus.BUSY[g] = pend_q[ra] && (ra != '0) && !hit1;
    end

    assign bus.A0     = mem_q[ADDR_W'(4)];
    assign bus.V0     = mem_q[ADDR_W'(2)];
    assign bus.RA_TAP = mem_q[ADDR_W'(31)];
endmodule
